// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the CPU memory stage and a byte-addressed little-endian data memory.
// Optional macro LSU_MISALIGN_EN: misaligned requests are split into byte transfers instead of rejected.
module lsu_mem_initiator #(
    parameter int MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [63:0] resp_rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_writeData,
    output logic        mem_writeEnable,
    output logic        mem_readEnable,
    output logic [3:0]  mem_xferSize,
    input  logic [63:0] mem_readData
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic [64:0] LP_MEM_SIZE = 65'(MEM_SIZE);

    state_t      r_state, w_state_next;
    logic        r_write, w_write_next;
    logic [3:0]  r_size, w_size_next;
    logic        r_signed, w_signed_next;
    logic [63:0] r_mem_addr, w_mem_addr_next;
    logic [63:0] r_mem_wdata, w_mem_wdata_next;
    logic        r_mem_we, w_mem_we_next;
    logic        r_mem_re, w_mem_re_next;
    logic [3:0]  r_mem_xfer, w_mem_xfer_next;
    logic        r_resp_valid, w_resp_valid_next;
    logic        r_resp_error, w_resp_error_next;
    logic [63:0] r_resp_rdata, w_resp_rdata_next;

    logic        w_size_ok;
    logic        w_oob;
    logic        w_misalign;
    logic        w_reject;
    logic [64:0] w_end;

`ifdef LSU_MISALIGN_EN
    logic [63:0] r_addr, w_addr_next;
    logic [63:0] r_wdata, w_wdata_next;
    logic        r_split, w_split_next;
    logic [2:0]  r_k, w_k_next;
    logic [63:0] r_asm, w_asm_next;
    logic [63:0] w_asm_merged;
    logic [2:0]  w_k_inc;
    logic [63:0] w_wbyte_next;
    logic        w_last;
`endif

    function automatic logic [63:0] f_extend(input logic [63:0] d, input logic [3:0] size,
                                             input logic sgn);
        case (size)
            4'd1:    return {{56{sgn & d[7]}}, d[7:0]};
            4'd2:    return {{48{sgn & d[15]}}, d[15:0]};
            4'd4:    return {{32{sgn & d[31]}}, d[31:0]};
            default: return d;
        endcase
    endfunction

    // Bounds sum is taken in 65 bits so addresses near 2^64 cannot wrap into range.
    assign w_end      = {1'b0, req_addr} + {61'd0, req_size};
    assign w_oob      = (w_end > LP_MEM_SIZE);
    assign w_size_ok  = (req_size == 4'd1) || (req_size == 4'd2) ||
                        (req_size == 4'd4) || (req_size == 4'd8);
    assign w_misalign = |(req_addr[3:0] & (req_size - 4'd1));

`ifdef LSU_MISALIGN_EN
    assign w_reject = !w_size_ok || w_oob;
    assign w_k_inc  = r_k + 3'd1;
    assign w_last   = ({1'b0, r_k} == (r_size - 4'd1));
    assign w_wbyte_next = r_wdata >> {w_k_inc, 3'b000};

    // Byte lane k of the assembly register takes the current read byte.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_asm_lane
            assign w_asm_merged[8*gi +: 8] = (r_k == 3'(gi)) ? mem_readData[7:0]
                                                             : r_asm[8*gi +: 8];
        end
    endgenerate
`else
    assign w_reject = !w_size_ok || w_oob || w_misalign;
`endif

    always_comb begin
        w_state_next      = r_state;
        w_write_next      = r_write;
        w_size_next       = r_size;
        w_signed_next     = r_signed;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;
        w_mem_we_next     = 1'b0;
        w_mem_re_next     = 1'b0;
        w_mem_xfer_next   = r_mem_xfer;
        w_resp_valid_next = 1'b0;
        w_resp_error_next = r_resp_error;
        w_resp_rdata_next = r_resp_rdata;
`ifdef LSU_MISALIGN_EN
        w_addr_next       = r_addr;
        w_wdata_next      = r_wdata;
        w_split_next      = r_split;
        w_k_next          = r_k;
        w_asm_next        = r_asm;
`endif
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_write_next  = req_write;
                    w_size_next   = req_size;
                    w_signed_next = req_signed;
                    if (w_reject) begin
                        w_state_next      = S_RESP;
                        w_resp_valid_next = 1'b1;
                        w_resp_error_next = 1'b1;
                        w_resp_rdata_next = 64'd0;
                    end else begin
                        w_state_next    = S_ACCESS;
                        w_mem_addr_next = req_addr;
                        w_mem_we_next   = req_write;
                        w_mem_re_next   = !req_write;
`ifdef LSU_MISALIGN_EN
                        w_addr_next      = req_addr;
                        w_wdata_next     = req_wdata;
                        w_split_next     = w_misalign;
                        w_k_next         = 3'd0;
                        w_asm_next       = 64'd0;
                        w_mem_xfer_next  = w_misalign ? 4'd1 : req_size;
                        w_mem_wdata_next = w_misalign ? {56'd0, req_wdata[7:0]} : req_wdata;
`else
                        w_mem_xfer_next  = req_size;
                        w_mem_wdata_next = req_wdata;
`endif
                    end
                end
            end
            S_ACCESS: begin
`ifdef LSU_MISALIGN_EN
                if (r_split) begin
                    w_asm_next = w_asm_merged;
                    if (w_last) begin
                        w_state_next      = S_RESP;
                        w_resp_valid_next = 1'b1;
                        w_resp_error_next = 1'b0;
                        w_resp_rdata_next = r_write ? 64'd0
                                                    : f_extend(w_asm_merged, r_size, r_signed);
                    end else begin
                        w_k_next         = w_k_inc;
                        w_mem_addr_next  = r_addr + {61'd0, w_k_inc};
                        w_mem_wdata_next = {56'd0, w_wbyte_next[7:0]};
                        w_mem_we_next    = r_write;
                        w_mem_re_next    = !r_write;
                    end
                end else begin
                    w_state_next      = S_RESP;
                    w_resp_valid_next = 1'b1;
                    w_resp_error_next = 1'b0;
                    w_resp_rdata_next = r_write ? 64'd0 : f_extend(mem_readData, r_size, r_signed);
                end
`else
                w_state_next      = S_RESP;
                w_resp_valid_next = 1'b1;
                w_resp_error_next = 1'b0;
                w_resp_rdata_next = r_write ? 64'd0 : f_extend(mem_readData, r_size, r_signed);
`endif
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write      <= 1'b0;
            r_size       <= 4'd8;
            r_signed     <= 1'b0;
            r_mem_addr   <= 64'd0;
            r_mem_wdata  <= 64'd0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_xfer   <= 4'd8;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= 64'd0;
`ifdef LSU_MISALIGN_EN
            r_addr       <= 64'd0;
            r_wdata      <= 64'd0;
            r_split      <= 1'b0;
            r_k          <= 3'd0;
            r_asm        <= 64'd0;
`endif
        end else begin
            r_write      <= w_write_next;
            r_size       <= w_size_next;
            r_signed     <= w_signed_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_mem_we     <= w_mem_we_next;
            r_mem_re     <= w_mem_re_next;
            r_mem_xfer   <= w_mem_xfer_next;
            r_resp_valid <= w_resp_valid_next;
            r_resp_error <= w_resp_error_next;
            r_resp_rdata <= w_resp_rdata_next;
`ifdef LSU_MISALIGN_EN
            r_addr       <= w_addr_next;
            r_wdata      <= w_wdata_next;
            r_split      <= w_split_next;
            r_k          <= w_k_next;
            r_asm        <= w_asm_next;
`endif
        end
    end

    assign req_ready       = (r_state == S_IDLE);
    assign resp_valid      = r_resp_valid;
    assign resp_error      = r_resp_error;
    assign resp_rdata      = r_resp_rdata;
    assign mem_addr        = r_mem_addr;
    assign mem_writeData   = r_mem_wdata;
    assign mem_writeEnable = r_mem_we;
    assign mem_readEnable  = r_mem_re;
    assign mem_xferSize    = r_mem_xfer;

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
Load/store initiator that sits between the CPU memory stage and the byte-addressed little-endian data memory, and drives that memory's request interface. It accepts one load or store at a time and validates size and bounds. Aligned accesses are issued as a single memory transfer. Loads return data zero- or sign-extended to 64 bits with a single-cycle response pulse.

Parameters:
MEM_SIZE, 1024, data memory size in bytes; power of 2, greater than 8.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  CPU request present
req_ready  output  1  initiator can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  64  byte address
req_wdata  input  64  store data; low req_size bytes used
req_size  input  4  transfer size in bytes: 1, 2, 4 or 8
req_signed  input  1  load sign-extends when 1
resp_valid  output  1  one-cycle completion pulse
resp_error  output  1  qualifies resp_valid; request rejected
resp_rdata  output  64  extended load data
mem_addr  output  64  to memory addr
mem_writeData  output  64  to memory writeData
mem_writeEnable  output  1  to memory writeEnable
mem_readEnable  output  1  to memory readEnable
mem_xferSize  output  4  to memory xferSize
mem_readData  input  64  from memory; combinational, valid in the same cycle as mem_readEnable

Behaviour:
- Reset (async, reset_n low) values:
  - state = IDLE, req_ready = 1
  - resp_valid = 0, resp_error = 0, resp_rdata = 0
  - mem enables = 0, mem_addr = 0, mem_xferSize = 8
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, the request is captured at the clock edge.
  - Error if req_size is not in {1, 2, 4, 8}, or req_addr + req_size > MEM_SIZE (compute the sum in 65 bits). On error: go to RESP with resp_error = 1 and no memory enable ever asserted.
  - Otherwise: go to ACCESS.
- ACCESS:
  - req_ready = 0; req_valid is ignored.
  - Aligned request (addr mod size == 0): exactly one cycle with mem_addr = addr, mem_xferSize = size, and the write or read enable asserted.
  - Store: mem_writeData = req_wdata.
  - Load: mem_readData is captured at the end of the cycle.
  - Misaligned request: see Optional Feature.
  - Go to RESP after the final transfer.
- RESP:
  - resp_valid = 1 for exactly one cycle; return to IDLE.
  - No backpressure; the CPU must take the response.
- Load data:
  - Size 1/2/4: bits above 8*size are replicated from the top data bit when req_signed = 1, else zero.
  - Size 8: passed through unchanged.
- Stores and errors set resp_rdata = 0. resp_rdata holds until the next response.
- Exactly one of mem_readEnable and mem_writeEnable is high during ACCESS; both are low in IDLE and RESP. All mem_* outputs are driven from registered state (glitch-free).
- Latency, measured from the accepting edge to the resp_valid cycle:
  - Aligned access: 2 cycles.
  - Error: 1 cycle.
  - Split access: 1 + size cycles.
- Reset mid-operation:
  - Enables drop immediately and no response is issued.
  - A split store may be left partially written; this is permitted.
  - Aligned stores are atomic.

Optional Feature:
- Macro: LSU_MISALIGN_EN.
- Defined: a misaligned valid request is split into req_size byte transfers in ACCESS.
  - A byte counter k runs 0..size-1.
  - Each cycle drives mem_xferSize = 1, mem_addr = addr + k, mem_writeData[7:0] = wdata byte k.
  - For loads, mem_readData[7:0] is placed into byte k of the assembly register.
  - Extension is applied after the last byte; go to RESP when k = size-1.
- Undefined: a misaligned request is an error. It goes to RESP with resp_error = 1, one cycle latency, and no enables are asserted.

Test Plan:
1. Store size 8 @0x10 data 0x0123456789ABCDEF, then load size 8 @0x10.
   -> Each request has one ACCESS cycle with xferSize = 8. Load resp_rdata = 0x0123456789ABCDEF, resp_valid 2 cycles after accept, req_ready low while busy.
2. Store size 1 @0x20 data 0x80; load size 1 @0x20 with req_signed = 1, then with req_signed = 0.
   -> resp_rdata = 0xFFFFFFFFFFFFFF80, then 0x0000000000000080.
3. With LSU_MISALIGN_EN: store size 4 @0x21 data 0xDEADBEEF; load size 4 @0x21 unsigned.
   -> Each access is 4 byte transfers at 0x21..0x24 with xferSize = 1. Load resp_rdata = 0x00000000DEADBEEF after 5 cycles.
   Without the macro: resp_error = 1 and no enables ever asserted.
4. Load size 8 @0x3FC (MEM_SIZE = 1024); request with size 3 @0x0.
   -> Each gives resp_error = 1 one cycle after accept, resp_rdata = 0, no mem enables.
5. Drive reset_n low during the 2nd byte of a split store.
   -> mem_writeEnable falls without a clock edge, resp_valid stays 0, req_ready = 1 after release, and the next aligned load completes normally.
6. Hold req_valid high back-to-back with different addresses.
   -> Each request is accepted only in IDLE (one every 3 cycles aligned). No request is lost or duplicated, and each response matches its request in order.
